mod_counter_cfg: RTL and testbench



---
 rtl/timer_pkg.sv | 12 +
 rtl/mod_counter_cfg.sv | 67 ++++++
 tb/tb_mod_counter_cfg.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timekeeping counter chain: count direction
// encodings and the standard moduli for seconds, minutes and hours stages.
package timer_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HR_MOD  = 24;

endpackage

// File: rtl/mod_counter_cfg.sv
// Configurable modulo-N up/down counter with synchronous clear/load, wrap or
// saturate at the terminal value, a sticky overflow flag and a cascade output.
module mod_counter_cfg
  import timer_pkg::*;
#(
  parameter int MODULUS = SEC_MOD,
  parameter int WIDTH   = $clog2(MODULUS),
  parameter bit WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             ovf_ack,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             ovf,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic             at_term;
  logic             load_ok;
  logic [WIDTH-1:0] step_val;

  // Terminal depends on the live dir, so done follows a direction change in the same cycle.
  always_comb begin
    at_term  = (dir == DIR_UP) ? (count == MAX_VAL) : (count == '0);
    load_ok  = ({1'b0, load_val} < MOD_EXT);
    done     = enable & ~clear & ~load & at_term;
    step_val = count;
    if (!at_term) begin
      step_val = (dir == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
    end else if (WRAP) begin
      step_val = (dir == DIR_UP) ? '0 : MAX_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      // A set in the same cycle as an acknowledge keeps the flag raised.
      ovf      <= done | (ovf & ~ovf_ack);
      load_err <= load & ~load_ok;
      if (load) begin
        if (load_ok) begin
          count <= load_val;
        end
      end else if (enable) begin
        count <= step_val;
      end
    end
  end

endmodule

// File: tb/tb_mod_counter_cfg.sv
// Self-checking bench: a seconds counter cascaded into a minutes counter, plus
// a saturating hours-sized instance, driven by a vector table and sequences.
module tb_mod_counter_cfg;
  import timer_pkg::*;

  typedef struct {
    logic       clear;
    logic       load;
    logic [5:0] load_val;
    logic       dir;
    logic       enable;
    logic       ovf_ack;
    logic       exp_done;
    logic [5:0] exp_count;
    logic       exp_ovf;
    logic       exp_le;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       enable = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b1, ovf_ack = 1'b0;
  logic [5:0] load_val = '0;
  logic [5:0] count;
  logic       done, ovf, load_err;

  logic [5:0] m_count;
  logic       m_done, m_ovf, m_le;

  logic       s_enable = 1'b0, s_load = 1'b0, s_dir = 1'b1;
  logic [4:0] s_load_val = '0;
  logic [4:0] s_count;
  logic       s_done, s_ovf, s_le;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_counter_cfg #(.MODULUS(SEC_MOD), .WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
    .load_val(load_val), .dir(dir), .ovf_ack(ovf_ack),
    .count(count), .done(done), .ovf(ovf), .load_err(load_err)
  );

  mod_counter_cfg #(.MODULUS(MIN_MOD), .WRAP(1'b1)) minutes (
    .clk(clk), .rst(rst), .enable(done), .clear(1'b0), .load(1'b0),
    .load_val(6'd0), .dir(DIR_UP), .ovf_ack(1'b0),
    .count(m_count), .done(m_done), .ovf(m_ovf), .load_err(m_le)
  );

  mod_counter_cfg #(.MODULUS(HR_MOD), .WRAP(1'b0)) sat (
    .clk(clk), .rst(rst), .enable(s_enable), .clear(1'b0), .load(s_load),
    .load_val(s_load_val), .dir(s_dir), .ovf_ack(1'b0),
    .count(s_count), .done(s_done), .ovf(s_ovf), .load_err(s_le)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic l, input int lv, input logic d,
                              input logic e, input logic a, input logic xd, input int xc,
                              input logic xo, input logic xl);
    vec_t v;
    v.clear = c; v.load = l; v.load_val = 6'(lv); v.dir = d; v.enable = e; v.ovf_ack = a;
    v.exp_done = xd; v.exp_count = 6'(xc); v.exp_ovf = xo; v.exp_le = xl;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    clear = v.clear; load = v.load; load_val = v.load_val;
    dir = v.dir; enable = v.enable; ovf_ack = v.ovf_ack;
    #1;
    checkOutput($sformatf("vec%0d done", idx), 32'(done), 32'(v.exp_done));
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d count", idx), 32'(count), 32'(v.exp_count));
    checkOutput($sformatf("vec%0d ovf", idx), 32'(ovf), 32'(v.exp_ovf));
    checkOutput($sformatf("vec%0d load_err", idx), 32'(load_err), 32'(v.exp_le));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset ovf", 32'(ovf), 32'd0);
    checkOutput("reset load_err", 32'(load_err), 32'd0);
    rst = 1'b0;
  endtask

  vec_t vecs[21];

  initial begin
    int pulses, pulse_cycle, wraps;
    logic pulse_ok;
    logic [5:0] prev_m;

    vecs[0]  = mk(0, 1, 42, 1, 0, 0,  0, 42, 0, 0);
    vecs[1]  = mk(0, 1, 60, 1, 1, 0,  0, 42, 0, 1);
    vecs[2]  = mk(0, 0,  0, 1, 0, 0,  0, 42, 0, 0);
    vecs[3]  = mk(0, 1, 10, 1, 1, 0,  0, 10, 0, 0);
    vecs[4]  = mk(0, 0,  0, 1, 1, 0,  0, 11, 0, 0);
    vecs[5]  = mk(0, 0,  0, DIR_DOWN, 1, 0, 0, 10, 0, 0);
    vecs[6]  = mk(0, 1, 59, 1, 0, 0,  0, 59, 0, 0);
    vecs[7]  = mk(1, 0,  0, 1, 1, 0,  0,  0, 0, 0);
    vecs[8]  = mk(0, 1, 59, 1, 0, 0,  0, 59, 0, 0);
    vecs[9]  = mk(0, 0,  0, 1, 1, 1,  1,  0, 1, 0);
    vecs[10] = mk(0, 0,  0, 1, 0, 0,  0,  0, 1, 0);
    vecs[11] = mk(0, 0,  0, 1, 0, 1,  0,  0, 0, 0);
    vecs[12] = mk(0, 0,  0, DIR_DOWN, 1, 0, 1, 59, 1, 0);
    vecs[13] = mk(0, 0,  0, 1, 1, 0,  1,  0, 1, 0);
    vecs[14] = mk(1, 1,  5, 1, 1, 0,  0,  0, 0, 0);
    vecs[15] = mk(0, 1, 63, 1, 0, 0,  0,  0, 0, 1);
    vecs[16] = mk(0, 0,  0, 1, 1, 0,  0,  1, 0, 0);
    vecs[17] = mk(0, 0,  0, DIR_DOWN, 1, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 0,  0, DIR_DOWN, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 1, 60, 1, 0, 0,  0,  0, 0, 1);
    vecs[20] = mk(1, 0,  0, 1, 0, 0,  0,  0, 0, 0);

    // Free-running up count from reset through one wrap.
    enable = 1'b1; dir = 1'b1;
    doReset();
    for (int i = 0; i < 60; i++) begin
      #1;
      checkOutput($sformatf("run count@%0d", i), 32'(count), 32'(i));
      checkOutput($sformatf("run done@%0d", i), 32'(done), 32'(i == 59));
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checkOutput("run wrap count", 32'(count), 32'd0);
    checkOutput("run wrap ovf", 32'(ovf), 32'd1);
    checkOutput("run minutes step", 32'(m_count), 32'd1);
    enable = 1'b0;

    doReset();
    for (int i = 0; i < 21; i++) applyStimulus(vecs[i], i);
    clear = 1'b0; load = 1'b0; enable = 1'b0; ovf_ack = 1'b0; dir = 1'b1;

    // Saturating instance: down at 0 holds, up at 23 holds, illegal load of 24.
    @(negedge clk);
    s_dir = DIR_DOWN; s_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("sat down done%0d", i), 32'(s_done), 32'd1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("sat down count%0d", i), 32'(s_count), 32'd0);
      checkOutput($sformatf("sat down ovf%0d", i), 32'(s_ovf), 32'd1);
      @(negedge clk);
    end
    s_enable = 1'b0; s_load = 1'b1; s_load_val = 5'd23; s_dir = DIR_UP;
    @(negedge clk);
    s_load = 1'b0; s_enable = 1'b1;
    #1;
    checkOutput("sat up done", 32'(s_done), 32'd1);
    @(negedge clk);
    checkOutput("sat up hold", 32'(s_count), 32'd23);
    s_enable = 1'b0; s_load = 1'b1; s_load_val = 5'd24;
    @(negedge clk);
    s_load = 1'b0;
    checkOutput("sat bad load count", 32'(s_count), 32'd23);
    checkOutput("sat bad load err", 32'(s_le), 32'd1);
    @(negedge clk);
    checkOutput("sat load err pulse end", 32'(s_le), 32'd0);

    // Asynchronous reset in the middle of a cycle while ovf is set.
    load = 1'b1; load_val = 6'd59;
    @(negedge clk);
    load = 1'b0; enable = 1'b1; dir = 1'b1;
    @(negedge clk);
    enable = 1'b0; load = 1'b1; load_val = 6'd37;
    @(negedge clk);
    load = 1'b0;
    checkOutput("pre-rst count", 32'(count), 32'd37);
    checkOutput("pre-rst ovf", 32'(ovf), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async rst count", 32'(count), 32'd0);
    checkOutput("async rst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0; enable = 1'b1; dir = 1'b1;
    checkOutput("post-rst count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("post-rst step", 32'(count), 32'd1);
    enable = 1'b0;

    // Seconds -> minutes cascade over one full hour.
    doReset();
    pulses = 0; pulse_cycle = -1; wraps = 0; pulse_ok = 1'b0;
    @(negedge clk);
    enable = 1'b1; dir = 1'b1;
    for (int i = 0; i < 3600; i++) begin
      #1;
      if (m_done) begin
        pulses++;
        pulse_cycle = i;
        pulse_ok = (count == 6'd59) && (m_count == 6'd59);
      end
      prev_m = m_count;
      @(posedge clk);
      #1;
      if (prev_m == 6'd59 && m_count == 6'd0) wraps++;
      @(negedge clk);
    end
    enable = 1'b0;
    checkOutput("cascade pulses", 32'(pulses), 32'd1);
    checkOutput("cascade pulse cycle", 32'(pulse_cycle), 32'd3599);
    checkOutput("cascade pulse at 59:59", 32'(pulse_ok), 32'd1);
    checkOutput("cascade wraps", 32'(wraps), 32'd1);
    checkOutput("cascade sec end", 32'(count), 32'd0);
    checkOutput("cascade min end", 32'(m_count), 32'd0);
    checkOutput("cascade min ovf", 32'(m_ovf), 32'd1);
    checkOutput("cascade min load_err", 32'(m_le), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
